// File: rtl/coef_loader_pkg.sv
// coef_loader_pkg
//   Shared definitions for the coefficient loader. These are the default
//   geometry values and the loader state encoding. The control FSM and the
//   FIR datapath use the same encoding.
package coef_loader_pkg;

    localparam int N_COEF_DEF  = 16;
    localparam int COEF_W_DEF  = 12;
    localparam int TIMEOUT_DEF = 1000000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } ld_state_t;

endpackage

// File: rtl/coef_loader_regfile.sv
// coef_loader_regfile
//   Coefficient bank of N_COEF x COEF_W registers. It has one write port and
//   one registered read port, and it also drives the whole bank as a flat
//   vector.
//   Ports:
//     clk_i, rst_i  clock, async active-high reset (clears the bank)
//     wr_en_i       write strobe
//     wr_addr_i     write index
//     wr_data_i     write data
//     rd_addr_i     read index
//     rd_data_o     bank[rd_addr_i], 1-cycle latency (old value on same-cycle write)
//     coef_all_o    flat bank, coef k at [k*COEF_W +: COEF_W]
module coef_loader_regfile
    import coef_loader_pkg::*;
#(
    parameter int N_COEF = N_COEF_DEF,
    parameter int COEF_W = COEF_W_DEF,
    parameter int IDX_W  = $clog2(N_COEF)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en_i,
    input  logic [IDX_W-1:0]         wr_addr_i,
    input  logic [COEF_W-1:0]        wr_data_i,
    input  logic [IDX_W-1:0]         rd_addr_i,
    output logic [COEF_W-1:0]        rd_data_o,
    output logic [N_COEF*COEF_W-1:0] coef_all_o
);

    logic [COEF_W-1:0] bank_q [N_COEF];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < N_COEF; k++) begin
                bank_q[k] <= '0;
            end
            rd_data_o <= '0;
        end else begin
            if (wr_en_i) begin
                bank_q[wr_addr_i] <= wr_data_i;
            end
            rd_data_o <= bank_q[rd_addr_i];
        end
    end

    for (genvar g = 0; g < N_COEF; g++) begin : g_flat
        assign coef_all_o[g*COEF_W +: COEF_W] = bank_q[g];
    end

endmodule

// File: rtl/coef_loader.sv
// coef_loader
//   This block packs pairs of UART bytes (low byte first) into COEF_W-bit
//   coefficients. It stores a block of N_COEF coefficients and flags when the
//   block is complete. A rising edge on en_recepcion_i starts a block, and
//   dropping it mid-block aborts.
//   Ports:
//     clk_i, rst_i      clock, async active-high reset
//     en_recepcion_i    load enable (rising edge = start)
//     rx_data_i         received byte
//     rx_valid_i        1-cycle byte strobe
//     coef_rd_addr_i    read index
//     coef_rd_data_o    registered read data
//     coef_all_o        flat coefficient bank
//     coef_wr_o         pulse per stored coefficient
//     coef_idx_o        index being loaded / index just written
//     fin_block_coef_o  high while a complete block is held
//     err_timeout_o     pulse when the high byte never arrived
//
//   state | meaning
//   IDLE  | waiting for en_recepcion_i rising edge
//   LOW   | waiting for low byte of coefficient idx
//   HIGH  | low byte held, waiting for high byte (timer running)
//   DONE  | full block stored, fin_block_coef_o held high
module coef_loader
    import coef_loader_pkg::*;
#(
    parameter int N_COEF      = N_COEF_DEF,
    parameter int COEF_W      = COEF_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        en_recepcion_i,
    input  logic [7:0]                  rx_data_i,
    input  logic                        rx_valid_i,
    input  logic [$clog2(N_COEF)-1:0]   coef_rd_addr_i,
    output logic [COEF_W-1:0]           coef_rd_data_o,
    output logic [N_COEF*COEF_W-1:0]    coef_all_o,
    output logic                        coef_wr_o,
    output logic [$clog2(N_COEF)-1:0]   coef_idx_o,
    output logic                        fin_block_coef_o,
    output logic                        err_timeout_o
);

    localparam int IDX_W = $clog2(N_COEF);
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    ld_state_t          state_q, state_n;
    logic               en_d_q;
    logic [IDX_W-1:0]   idx_q, idx_n;
    logic [IDX_W-1:0]   coef_idx_q;
    logic               fin_q, fin_n;
    logic [TMR_W-1:0]   timer_q, timer_n;
    logic [7:0]         low_q, low_n;
    logic               wr_q, err_q, err_n;
    logic               wr_en;
    logic               start;

    assign start = en_recepcion_i & ~en_d_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            en_d_q     <= 1'b0;
            idx_q      <= '0;
            coef_idx_q <= '0;
            fin_q      <= 1'b0;
            timer_q    <= '0;
            low_q      <= '0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_n;
            en_d_q     <= en_recepcion_i;
            idx_q      <= idx_n;
            // While the write pulse is high, show the index that was just written.
            coef_idx_q <= wr_en ? idx_q : idx_n;
            fin_q      <= fin_n;
            timer_q    <= timer_n;
            low_q      <= low_n;
            wr_q       <= wr_en;
            err_q      <= err_n;
        end
    end

    // Priority order: abort, then start, then byte, then timeout.
    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        fin_n   = fin_q;
        timer_n = timer_q;
        low_n   = low_q;
        wr_en   = 1'b0;
        err_n   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_LOW;
                    idx_n   = '0;
                    fin_n   = 1'b0;
                end
            end
            ST_LOW, ST_HIGH: begin
                if (!en_recepcion_i) begin
                    state_n = ST_IDLE;
                    idx_n   = '0;
                    fin_n   = 1'b0;
                    timer_n = '0;
                end else if (start) begin
                    state_n = ST_LOW;
                    idx_n   = '0;
                    fin_n   = 1'b0;
                    timer_n = '0;
                end else if (state_q == ST_LOW) begin
                    if (rx_valid_i) begin
                        low_n   = rx_data_i;
                        timer_n = '0;
                        state_n = ST_HIGH;
                    end
                end else if (rx_valid_i) begin
                    wr_en = 1'b1;
                    if (idx_q == IDX_W'(N_COEF - 1)) begin
                        state_n = ST_DONE;
                        fin_n   = 1'b1;
                    end else begin
                        idx_n   = idx_q + IDX_W'(1);
                        state_n = ST_LOW;
                    end
                end else if (timer_q == TMR_W'(TIMEOUT_CYC)) begin
                    // Drop the orphaned low byte and wait for a fresh pair at the same index.
                    err_n   = 1'b1;
                    timer_n = '0;
                    state_n = ST_LOW;
                end else begin
                    timer_n = timer_q + TMR_W'(1);
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_n = ST_LOW;
                    idx_n   = '0;
                    fin_n   = 1'b0;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    coef_loader_regfile #(
        .N_COEF (N_COEF),
        .COEF_W (COEF_W),
        .IDX_W  (IDX_W)
    ) u_regfile (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wr_en_i    (wr_en),
        .wr_addr_i  (idx_q),
        .wr_data_i  ({rx_data_i[COEF_W-9:0], low_q}),
        .rd_addr_i  (coef_rd_addr_i),
        .rd_data_o  (coef_rd_data_o),
        .coef_all_o (coef_all_o)
    );

    assign coef_wr_o        = wr_q;
    assign coef_idx_o       = coef_idx_q;
    assign fin_block_coef_o = fin_q;
    assign err_timeout_o    = err_q;

endmodule

// File: tb/tb_coef_loader.sv
module tb_coef_loader;

    localparam int N  = 16;
    localparam int W  = 12;
    localparam int TO = 20;
    localparam int IW = 4;
    localparam int CW = N * W;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          en_recepcion_i = 1'b0;
    logic [7:0]    rx_data_i = '0;
    logic          rx_valid_i = 1'b0;
    logic [IW-1:0] coef_rd_addr_i = '0;
    logic [W-1:0]  coef_rd_data_o;
    logic [CW-1:0] coef_all_o;
    logic          coef_wr_o;
    logic [IW-1:0] coef_idx_o;
    logic          fin_block_coef_o;
    logic          err_timeout_o;

    coef_loader #(.N_COEF(N), .COEF_W(W), .TIMEOUT_CYC(TO)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .en_recepcion_i   (en_recepcion_i),
        .rx_data_i        (rx_data_i),
        .rx_valid_i       (rx_valid_i),
        .coef_rd_addr_i   (coef_rd_addr_i),
        .coef_rd_data_o   (coef_rd_data_o),
        .coef_all_o       (coef_all_o),
        .coef_wr_o        (coef_wr_o),
        .coef_idx_o       (coef_idx_o),
        .fin_block_coef_o (fin_block_coef_o),
        .err_timeout_o    (err_timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    int wr_seen = 0;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [W-1:0]  data;
    } wr_t;

    wr_t          exp_q[$];
    logic [W-1:0] model [N];

    typedef struct {
        logic [7:0]   lo;
        logic [7:0]   hi;
        logic [W-1:0] coef;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_coef(input logic [7:0] lo, input logic [7:0] hi);
        logic [W-1:0] c;
        c = W'(lo) | (W'(hi & 8'h0F) << 8);
        return c;
    endfunction

    // Scoreboard: every write pulse must match the oldest expected write.
    always @(negedge clk_i) begin
        wr_t e;
        if (!rst_i && coef_wr_o) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_wr: got idx %0d expected no write", coef_idx_o);
            end else begin
                e = exp_q.pop_front();
                check("wr_idx", CW'(coef_idx_o), CW'(e.idx));
                check("wr_data", CW'(coef_all_o[e.idx*W +: W]), CW'(e.data));
                model[e.idx] = e.data;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk_i); #1;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        @(posedge clk_i); #1;
        rx_valid_i = 1'b0;
    endtask

    task automatic send_pair(input logic [7:0] lo, input logic [7:0] hi, input int idx);
        send_byte(lo);
        exp_q.push_back('{idx: IW'(idx), data: exp_coef(lo, hi)});
        send_byte(hi);
    endtask

    task automatic start_block();
        @(posedge clk_i); #1;
        en_recepcion_i = 1'b0;
        @(posedge clk_i); #1;
        en_recepcion_i = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic check_bank(input string name);
        logic [CW-1:0] flat;
        for (int k = 0; k < N; k++) flat[k*W +: W] = model[k];
        check(name, coef_all_o, flat);
    endtask

    task automatic drain(input string name);
        repeat (3) @(negedge clk_i);
        check(name, CW'(exp_q.size()), '0);
    endtask

    initial begin
        logic [CW-1:0] v;
        int n;
        int w0;
        bit got;

        tbl[0] = '{lo: 8'hFF, hi: 8'hAF, coef: 12'hFFF};
        tbl[1] = '{lo: 8'h34, hi: 8'h12, coef: 12'h234};
        tbl[2] = '{lo: 8'h00, hi: 8'h08, coef: 12'h800};
        tbl[3] = '{lo: 8'hFF, hi: 8'h07, coef: 12'h7FF};
        tbl[4] = '{lo: 8'hAA, hi: 8'hF5, coef: 12'h5AA};
        for (int k = 0; k < N; k++) model[k] = '0;

        // 1. reset state and sequential block
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_idx", CW'(coef_idx_o), '0);
        check("rst_fin", CW'(fin_block_coef_o), '0);
        check("rst_err", CW'(err_timeout_o), '0);
        check("rst_wr", CW'(coef_wr_o), '0);
        check("rst_rd", CW'(coef_rd_data_o), '0);
        check("rst_bank", coef_all_o, '0);

        start_block();
        w0 = wr_seen;
        for (int k = 0; k < N - 1; k++) send_pair(8'(k + 1), 8'h00, k);
        send_byte(8'h10);
        check("fin_before_last", CW'(fin_block_coef_o), '0);
        exp_q.push_back('{idx: IW'(N - 1), data: 12'h010});
        send_byte(8'h00);
        @(negedge clk_i);
        check("fin_after_last", CW'(fin_block_coef_o), 1);
        check("last_wr_with_fin", CW'(coef_wr_o), 1);
        drain("t1_drain");
        check("t1_wr_count", CW'(wr_seen - w0), CW'(N));
        for (int k = 0; k < N; k++) v[k*W +: W] = W'(k + 1);
        check("t1_bank", coef_all_o, v);

        // 2. table-driven packing and readback; read during write sees old value
        coef_rd_addr_i = '0;
        start_block();
        check("t2_fin_clear", CW'(fin_block_coef_o), '0);
        for (int i = 0; i < 5; i++) begin
            send_byte(tbl[i].lo);
            exp_q.push_back('{idx: IW'(i), data: tbl[i].coef});
            send_byte(tbl[i].hi);
            if (i == 0) begin
                check("rd_old_on_write", CW'(coef_rd_data_o), 1);
                @(negedge clk_i);
                @(negedge clk_i);
                check("rd_new_after", CW'(coef_rd_data_o), CW'(12'hFFF));
            end
        end
        drain("t2_drain");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i); #1;
            coef_rd_addr_i = IW'(i);
            @(posedge clk_i);
            @(negedge clk_i);
            check("tbl_rd", CW'(coef_rd_data_o), CW'(tbl[i].coef));
        end
        check("t2_idx", CW'(coef_idx_o), 5);

        // 3. inter-byte timeout
        send_byte(8'h55);
        n = 0;
        got = 0;
        while (!got && n < TO + 10) begin
            @(negedge clk_i);
            n++;
            if (err_timeout_o) got = 1;
        end
        check("timeout_seen", CW'(got), 1);
        check("timeout_not_early", CW'(n >= TO), 1);
        @(negedge clk_i);
        check("timeout_pulse_1cyc", CW'(err_timeout_o), '0);
        check("timeout_idx_kept", CW'(coef_idx_o), 5);
        send_pair(8'h21, 8'h03, 5);
        drain("t3_drain");
        check("t3_coef", CW'(coef_all_o[5*W +: W]), CW'(12'h321));

        // 4. abort after 5 coefficients, then full reload
        start_block();
        for (int k = 0; k < 5; k++) send_pair(8'hA0 + 8'(k), 8'h01, k);
        @(posedge clk_i); #1;
        en_recepcion_i = 1'b0;
        @(posedge clk_i); #1;
        check("abort_fin", CW'(fin_block_coef_o), '0);
        check("abort_idx", CW'(coef_idx_o), '0);
        send_byte(8'h11);
        send_byte(8'h02);
        drain("t4_drain_abort");
        check_bank("abort_bank_kept");
        start_block();
        for (int k = 0; k < N; k++) begin
            if (k == 0) check("reload_idx0", CW'(coef_idx_o), '0);
            send_pair(8'(k * 17), 8'(k), k);
        end
        @(negedge clk_i);
        check("reload_fin", CW'(fin_block_coef_o), 1);
        drain("t4_drain");
        check_bank("t4_bank");

        // 5. bytes in DONE are ignored; en low in DONE keeps fin
        w0 = wr_seen;
        for (int k = 0; k < 4; k++) send_byte(8'hC3);
        @(posedge clk_i); #1;
        en_recepcion_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("done_fin_hold", CW'(fin_block_coef_o), 1);
        check("done_no_wr", CW'(wr_seen - w0), '0);
        check_bank("done_bank");
        @(posedge clk_i); #1;
        en_recepcion_i = 1'b1;
        @(posedge clk_i); #1;
        check("restart_fin_clear", CW'(fin_block_coef_o), '0);
        for (int k = 0; k < N; k++) send_pair(8'(255 - k), 8'(k + 3), k);
        @(negedge clk_i);
        check("t5_fin", CW'(fin_block_coef_o), 1);
        drain("t5_drain");
        check_bank("t5_bank");

        // 6. async reset mid-HIGH, then start coincident with a byte
        start_block();
        send_byte(8'h66);
        @(posedge clk_i);
        #3;
        rst_i = 1'b1;
        en_recepcion_i = 1'b0;
        #1;
        check("arst_bank", coef_all_o, '0);
        check("arst_fin", CW'(fin_block_coef_o), '0);
        check("arst_rd", CW'(coef_rd_data_o), '0);
        check("arst_idx", CW'(coef_idx_o), '0);
        exp_q.delete();
        for (int k = 0; k < N; k++) model[k] = '0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        en_recepcion_i = 1'b1;
        rx_data_i      = 8'h77;
        rx_valid_i     = 1'b1;
        @(posedge clk_i); #1;
        rx_valid_i     = 1'b0;
        send_pair(8'h9C, 8'h04, 0);
        drain("t6_drain");
        check("start_byte_dropped", CW'(coef_all_o[0 +: W]), CW'(12'h49C));
        check_bank("t6_bank");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
